panel_key_input: RTL

- Front-panel input side of the washing-machine controller; it feeds the display/LED path in the opposite direction.
- Samples the four raw panel buttons (power, start/pause, mode, water level), synchronizes and debounces them, and detects press and long-press events.
- Gates events against the current machine state.
- Emits single-cycle command pulses to the main controller FSM, using the same 3-bit state encoding the display path consumes.

---
 rtl/panel_key_input_if.sv | 26 ++
 rtl/panel_key_input.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/panel_key_input_if.sv
// panel_key_input_if: panel-side bundle between the key front end and the
// main controller. It carries the raw buttons, the controller state and the
// command pulses. The key front end uses the master modport because it
// drives the commands. The controller/bench side uses the slave modport.
interface panel_key_input_if;
  logic [2:0] state;
  logic       keyPower;
  logic       keyStart;
  logic       keyMode;
  logic       keyLevel;
  logic       powerCmd;
  logic       startCmd;
  logic       modeCmd;
  logic       levelCmd;
  logic       keyLED;

  modport master (
    input  state, keyPower, keyStart, keyMode, keyLevel,
    output powerCmd, startCmd, modeCmd, levelCmd, keyLED
  );

  modport slave (
    output state, keyPower, keyStart, keyMode, keyLevel,
    input  powerCmd, startCmd, modeCmd, levelCmd, keyLED
  );
endinterface

// File: rtl/panel_key_input.sv
// panel_key_input: front-panel key sampling, debounce, power long-press and
// state-gated single-cycle command pulses toward the main controller.
// Build macro AUTO_REPEAT_EN adds auto-repeat for held mode/level keys.

// One key lane: 2-flop synchronizer followed by a run-length debouncer.
module panel_key_lane #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic cp,
  input  logic rst_n,
  input  logic key_raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // shift the synchronizer; count samples disagreeing with the level, flip on the last one
  always_comb begin
    sync_d  = {sync_q[0], key_raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // lane state registers
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

module panel_key_input #(
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 250
) (
  input logic               cp,
  input logic               rst_n,
  panel_key_input_if.master bus
);
  localparam int NUM_LANES = 4;
  // lane order doubles as priority order: higher index wins
  localparam int K_PWR = 3;
  localparam int K_STA = 2;
  localparam int K_MOD = 1;
  localparam int K_LVL = 0;
  localparam int HW    = $clog2(LONG_PRESS_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } ctl_state_e;

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_param_chk
    $error("panel_key_input: illegal parameter combination");
  end

  logic [NUM_LANES-1:0] key_raw, level;
  logic [NUM_LANES-1:0] evt, allow, cand;
  logic [NUM_LANES-1:0] cmd_q, cmd_d;
  logic [2:0]           prev_q, prev_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 reach_q, reach_d;
  logic                 led_q, led_d;
  logic [1:0]           rep_evt;   // [1] mode, [0] level

  assign key_raw = {bus.keyPower, bus.keyStart, bus.keyMode, bus.keyLevel};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    panel_key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .cp      (cp),
      .rst_n   (rst_n),
      .key_raw (key_raw[g]),
      .level   (level[g])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [1:0][RW-1:0] rep_q, rep_d;

  // repeat phase runs 1..REPEAT_CYCLES while held; the top of the phase is a repeat
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_d[i] = '0;
      if (level[i]) rep_d[i] = (rep_q[i] == RW'(REPEAT_CYCLES)) ? RW'(1) : rep_q[i] + 1'b1;
    end
    rep_evt[1] = level[K_MOD] && (rep_q[1] == RW'(REPEAT_CYCLES));
    // a held mode key owns the repeat; level stays silent meanwhile
    rep_evt[0] = level[K_LVL] && !level[K_MOD] && (rep_q[0] == RW'(REPEAT_CYCLES));
  end

  // repeat phase registers
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_evt = '0;
`endif

  // power hold counter saturates one short of the limit; reach pulses once on arrival
  always_comb begin
    hold_d = '0;
    if (level[K_PWR])
      hold_d = (hold_q == HW'(LONG_PRESS_CYCLES - 1)) ? hold_q : hold_q + 1'b1;
    reach_d = level[K_PWR] && (hold_q == HW'(LONG_PRESS_CYCLES - 2));
  end

  // raw events: power long-press, rising edges of the others, plus repeats
  always_comb begin
    prev_d     = level[2:0];
    evt        = {reach_q & level[K_PWR], level[2:0] & ~prev_q};
    evt[K_MOD] = evt[K_MOD] | rep_evt[1];
    evt[K_LVL] = evt[K_LVL] | rep_evt[0];
  end

  // gate by the current controller state, keep only the highest-priority survivor
  always_comb begin
    allow = '0;
    case (bus.state)
      ST_BEGIN, ST_SET:            allow = 4'b1111;
      ST_RUN, ST_PAUSE, ST_FINISH: allow = 4'b1100;
      default:                     allow = 4'b1000;  // shutDown, error, 7
    endcase
    cand  = evt & allow;
    cmd_d = '0;
    if      (cand[K_PWR]) cmd_d[K_PWR] = 1'b1;
    else if (cand[K_STA]) cmd_d[K_STA] = 1'b1;
    else if (cand[K_MOD]) cmd_d[K_MOD] = 1'b1;
    else if (cand[K_LVL]) cmd_d[K_LVL] = 1'b1;
    led_d = |level;
  end

  // event, hold and output registers
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      hold_q  <= '0;
      reach_q <= 1'b0;
      cmd_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      reach_q <= reach_d;
      cmd_q   <= cmd_d;
      led_q   <= led_d;
    end
  end

  assign bus.powerCmd = cmd_q[K_PWR];
  assign bus.startCmd = cmd_q[K_STA];
  assign bus.modeCmd  = cmd_q[K_MOD];
  assign bus.levelCmd = cmd_q[K_LVL];
  assign bus.keyLED   = led_q;
endmodule
